// File: rtl/spart_baud_cfg.sv
// -----------------------------------------------------------------------------
// spart_baud_cfg
// Configuration sequencer for the SPART baud rate generator. After reset, and
// after every debounced change of the board baud-select switches, it writes the
// selected 16-bit divisor into the generator as a low-byte load followed by a
// high-byte load. In between auto sequences it forwards single-byte CPU divisor
// writes onto the same strobe/data bus; the auto sequence always has priority.
// All outputs come straight from flops: each output register is loaded with the
// value that belongs to the state being entered.
// -----------------------------------------------------------------------------
module spart_baud_cfg #(
    parameter logic [15:0] DIV0     = 16'h0516,
    parameter logic [15:0] DIV1     = 16'h028B,
    parameter logic [15:0] DIV2     = 16'h0145,
    parameter logic [15:0] DIV3     = 16'h00A2,
    parameter logic [15:0] DEBOUNCE = 16'd1000,
    parameter logic [7:0]  SETTLE   = 8'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_sel,
    input  logic       cpu_wr_req,
    input  logic       cpu_wr_hi,
    input  logic [7:0] cpu_wr_data,
    output logic       cpu_wr_ack,
    output logic       load_low,
    output logic       load_high,
    output logic [7:0] data_out,
    output logic       cfg_busy,
    output logic       cfg_done
);

    typedef enum logic [2:0] {
        ST_START   = 3'd0,
        ST_LOAD_LO = 3'd1,
        ST_LOAD_HI = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_READY   = 3'd4,
        ST_CPU_WR  = 3'd5
    } state_t;

    // Returns one byte of the divisor selected by sel (hi=1 -> bits 15:8).
    function automatic logic [7:0] div_byte(input logic [1:0] sel, input logic hi);
        logic [15:0] div_v;
        case (sel)
            2'b00:   div_v = DIV0;
            2'b01:   div_v = DIV1;
            2'b10:   div_v = DIV2;
            2'b11:   div_v = DIV3;
            default: div_v = DIV1;
        endcase
        if (hi) begin
            div_byte = div_v[15:8];
        end else begin
            div_byte = div_v[7:0];
        end
    endfunction

    // Switch synchronizer plus one history stage used to detect value changes.
    logic [1:0]  sync1_r, sync2_r, sync_prev_r;

    state_t      state_r, state_s;
    logic [1:0]  applied_sel_r, applied_sel_s;
    logic [15:0] deb_cnt_r, deb_cnt_s;
    logic [1:0]  start_cnt_r, start_cnt_s;
    logic [7:0]  settle_cnt_r, settle_cnt_s;

    logic        load_low_r, load_low_s;
    logic        load_high_r, load_high_s;
    logic [7:0]  data_out_r, data_out_s;
    logic        ack_r, ack_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;

    logic        sel_stable_s;
    logic        sel_diff_s;
    logic        deb_expire_s;

    assign sel_stable_s = (sync2_r == sync_prev_r);
    assign sel_diff_s   = (sync2_r != applied_sel_r);
    assign deb_expire_s = (state_r == ST_READY) && sel_stable_s && sel_diff_s &&
                          (deb_cnt_r == (DEBOUNCE - 16'd1));

    // Two-flop synchronizer for the asynchronous switches, plus change history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r     <= 2'b00;
            sync2_r     <= 2'b00;
            sync_prev_r <= 2'b00;
        end else begin
            sync1_r     <= br_sel;
            sync2_r     <= sync1_r;
            sync_prev_r <= sync2_r;
        end
    end

    // FSM state and sequencing counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_START;
            applied_sel_r <= 2'b00;
            deb_cnt_r     <= 16'd0;
            start_cnt_r   <= 2'd0;
            settle_cnt_r  <= 8'd0;
        end else begin
            state_r       <= state_s;
            applied_sel_r <= applied_sel_s;
            deb_cnt_r     <= deb_cnt_s;
            start_cnt_r   <= start_cnt_s;
            settle_cnt_r  <= settle_cnt_s;
        end
    end

    // Next-state logic and the output values that belong to the next state.
    always_comb begin
        state_s       = state_r;
        applied_sel_s = applied_sel_r;
        deb_cnt_s     = 16'd0;
        start_cnt_s   = start_cnt_r;
        settle_cnt_s  = settle_cnt_r;
        load_low_s    = 1'b0;
        load_high_s   = 1'b0;
        data_out_s    = data_out_r;
        ack_s         = 1'b0;
        busy_s        = 1'b1;
        done_s        = 1'b0;

        case (state_r)
            ST_START: begin
                // Two full cycles let the synchronizer fill before the first latch.
                if (start_cnt_r == 2'd2) begin
                    applied_sel_s = sync2_r;
                    state_s       = ST_LOAD_LO;
                    load_low_s    = 1'b1;
                    data_out_s    = div_byte(sync2_r, 1'b0);
                end else begin
                    start_cnt_s = start_cnt_r + 2'd1;
                end
            end
            ST_LOAD_LO: begin
                state_s     = ST_LOAD_HI;
                load_high_s = 1'b1;
                data_out_s  = div_byte(applied_sel_r, 1'b1);
            end
            ST_LOAD_HI: begin
                state_s      = ST_SETTLE;
                settle_cnt_s = 8'd1;
            end
            ST_SETTLE: begin
                if (settle_cnt_r >= (SETTLE - 8'd1)) begin
                    state_s = ST_READY;
                end else begin
                    settle_cnt_s = settle_cnt_r + 8'd1;
                end
            end
            ST_READY: begin
                // Debounce: count only while the new value is stable and differs.
                if (sel_diff_s && sel_stable_s) begin
                    if (deb_expire_s) begin
                        deb_cnt_s = 16'd0;
                    end else begin
                        deb_cnt_s = deb_cnt_r + 16'd1;
                    end
                end else begin
                    deb_cnt_s = 16'd0;
                end
                // Auto reconfiguration wins over a simultaneous CPU request.
                if (deb_expire_s) begin
                    applied_sel_s = sync2_r;
                    state_s       = ST_LOAD_LO;
                    load_low_s    = 1'b1;
                    data_out_s    = div_byte(sync2_r, 1'b0);
                end else if (cpu_wr_req) begin
                    state_s     = ST_CPU_WR;
                    load_high_s = cpu_wr_hi;
                    load_low_s  = ~cpu_wr_hi;
                    data_out_s  = cpu_wr_data;
                    ack_s       = 1'b1;
                end else begin
                    state_s = ST_READY;
                end
            end
            ST_CPU_WR: begin
                // Debounce progress is frozen for the single CPU write cycle.
                state_s   = ST_READY;
                deb_cnt_s = deb_cnt_r;
            end
            default: begin
                state_s     = ST_START;
                start_cnt_s = 2'd0;
            end
        endcase

        if ((state_s == ST_READY) || (state_s == ST_CPU_WR)) begin
            busy_s = 1'b0;
            done_s = 1'b1;
        end else begin
            busy_s = 1'b1;
            done_s = 1'b0;
        end
    end

    // Output registers, loaded with the values of the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_low_r  <= 1'b0;
            load_high_r <= 1'b0;
            data_out_r  <= 8'h00;
            ack_r       <= 1'b0;
            busy_r      <= 1'b1;
            done_r      <= 1'b0;
        end else begin
            load_low_r  <= load_low_s;
            load_high_r <= load_high_s;
            data_out_r  <= data_out_s;
            ack_r       <= ack_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

    assign load_low   = load_low_r;
    assign load_high  = load_high_r;
    assign data_out   = data_out_r;
    assign cpu_wr_ack = ack_r;
    assign cfg_busy   = busy_r;
    assign cfg_done   = done_r;

endmodule

// File: tb/tb_spart_baud_cfg.sv
// -----------------------------------------------------------------------------
// Testbench for spart_baud_cfg. The reference is a timeline model: the divisor
// table, the currently applied selection, and the cycle distances between a
// stimulus and the strobes it must produce (startup, debounce, settle).
// -----------------------------------------------------------------------------
module tb_spart_baud_cfg;

    localparam int D = 1000;
    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] br_sel = 2'b01;
    logic       cpu_wr_req = 1'b0;
    logic       cpu_wr_hi = 1'b0;
    logic [7:0] cpu_wr_data = 8'h00;
    logic       cpu_wr_ack;
    logic       load_low;
    logic       load_high;
    logic [7:0] data_out;
    logic       cfg_busy;
    logic       cfg_done;

    int checks = 0;
    int failures = 0;

    logic [15:0] div_tab [4];
    logic [1:0]  applied;
    logic [1:0]  sel;
    logic [1:0]  sel2;
    logic        rh;
    logic [7:0]  rd;

    logic [4:0]  ctrl_s;
    assign ctrl_s = {load_low, load_high, cpu_wr_ack, cfg_busy, cfg_done};

    spart_baud_cfg dut (
        .clk         (clk),
        .rst         (rst),
        .br_sel      (br_sel),
        .cpu_wr_req  (cpu_wr_req),
        .cpu_wr_hi   (cpu_wr_hi),
        .cpu_wr_data (cpu_wr_data),
        .cpu_wr_ack  (cpu_wr_ack),
        .load_low    (load_low),
        .load_high   (load_high),
        .data_out    (data_out),
        .cfg_busy    (cfg_busy),
        .cfg_done    (cfg_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // n cycles with no strobe and no ack; busy/done as given.
    task automatic quiet(input string tag, input int n, input logic busy);
        for (int i = 0; i < n; i++) begin
            tick();
            chk(tag, 16'(ctrl_s), 16'({2'b00, 1'b0, busy, ~busy}));
        end
    endtask

    task automatic exp_lo(input string tag, input logic [1:0] s);
        tick();
        chk({tag, "_lo_ctrl"}, 16'(ctrl_s), 16'(5'b10010));
        chk({tag, "_lo_data"}, 16'(data_out), 16'(div_tab[s][7:0]));
    endtask

    task automatic exp_rest(input string tag, input logic [1:0] s);
        tick();
        chk({tag, "_hi_ctrl"}, 16'(ctrl_s), 16'(5'b01010));
        chk({tag, "_hi_data"}, 16'(data_out), 16'(div_tab[s][15:8]));
        quiet({tag, "_settle"}, S - 1, 1'b1);
        tick();
        chk({tag, "_done"}, 16'(ctrl_s), 16'(5'b00001));
    endtask

    task automatic exp_auto(input string tag, input logic [1:0] s);
        exp_lo(tag, s);
        exp_rest(tag, s);
    endtask

    task automatic cpu_write(input string tag, input logic hi, input logic [7:0] d);
        cpu_wr_req  = 1'b1;
        cpu_wr_hi   = hi;
        cpu_wr_data = d;
        tick();
        chk({tag, "_ctrl"}, 16'(ctrl_s), 16'({~hi, hi, 1'b1, 1'b0, 1'b1}));
        chk({tag, "_data"}, 16'(data_out), 16'(d));
        cpu_wr_req = 1'b0;
        quiet({tag, "_after"}, 2, 1'b0);
    endtask

    initial begin
        div_tab[0] = 16'h0516;
        div_tab[1] = 16'h028B;
        div_tab[2] = 16'h0145;
        div_tab[3] = 16'h00A2;

        // Reset values while rst is held.
        #12;
        chk("rst_ctrl", 16'(ctrl_s), 16'(5'b00010));
        chk("rst_data", 16'(data_out), 16'h0000);

        // Startup: two idle edges, LO at edge 3, HI at edge 4, done at S+4.
        @(negedge clk);
        rst = 1'b0;
        quiet("start", 2, 1'b1);
        exp_auto("t1", 2'b01);
        applied = 2'b01;

        // Short glitch to another selection then back: nothing happens.
        br_sel = 2'b10;
        quiet("glitch_a", 20, 1'b0);
        br_sel = 2'b01;
        quiet("glitch_b", D + 20, 1'b0);

        // Held change: silent for the debounce window, then reconfigure.
        br_sel = 2'b11;
        quiet("deb_wait", D + 2, 1'b0);
        exp_auto("t2", 2'b11);
        applied = 2'b11;

        // CPU writes: directed then random.
        cpu_write("cpu_hi03", 1'b1, 8'h03);
        for (int i = 0; i < 4; i++) begin
            rh = 1'($urandom_range(0, 1));
            rd = 8'($urandom);
            cpu_write("cpu_rand", rh, rd);
        end

        // Request held past the ack is taken as a second write.
        cpu_wr_req  = 1'b1;
        cpu_wr_hi   = 1'b0;
        cpu_wr_data = 8'h5A;
        tick();
        chk("hold_ack1", 16'(ctrl_s), 16'(5'b10101));
        tick();
        chk("hold_gap", 16'(ctrl_s), 16'(5'b00001));
        tick();
        chk("hold_ack2", 16'(ctrl_s), 16'(5'b10101));
        chk("hold_data", 16'(data_out), 16'h005A);
        cpu_wr_req = 1'b0;
        quiet("hold_after", 2, 1'b0);

        // CPU request in the same cycle the debounce expires: auto first.
        sel = applied + 2'($urandom_range(1, 3));
        br_sel = sel;
        quiet("race_wait", D + 2, 1'b0);
        rh = 1'($urandom_range(0, 1));
        rd = 8'($urandom);
        cpu_wr_req  = 1'b1;
        cpu_wr_hi   = rh;
        cpu_wr_data = rd;
        exp_auto("race", sel);
        applied = sel;
        tick();
        chk("race_cpu_ctrl", 16'(ctrl_s), 16'({~rh, rh, 1'b1, 1'b0, 1'b1}));
        chk("race_cpu_data", 16'(data_out), 16'(rd));
        cpu_wr_req = 1'b0;
        quiet("race_after", 2, 1'b0);

        // Switch change during a sequence: it completes with the latched value,
        // then debounce starts counting on entry to READY.
        sel = applied + 2'($urandom_range(1, 3));
        br_sel = sel;
        quiet("mid_wait", D + 2, 1'b0);
        exp_lo("mid1", sel);
        sel2 = sel + 2'($urandom_range(1, 3));
        br_sel = sel2;
        exp_rest("mid1", sel);
        quiet("mid_deb", D - 1, 1'b0);
        exp_auto("mid2", sel2);
        applied = sel2;

        // Random reconfigurations with CPU writes in between.
        for (int i = 0; i < 3; i++) begin
            sel = applied + 2'($urandom_range(1, 3));
            br_sel = sel;
            quiet("rnd_wait", D + 2, 1'b0);
            exp_auto("rnd", sel);
            applied = sel;
            rh = 1'($urandom_range(0, 1));
            rd = 8'($urandom);
            cpu_write("rnd_cpu", rh, rd);
        end

        // Reset between the low and high loads.
        sel = applied + 2'($urandom_range(1, 3));
        br_sel = sel;
        quiet("rst_wait", D + 2, 1'b0);
        exp_lo("pre_rst", sel);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_ctrl", 16'(ctrl_s), 16'(5'b00010));
        chk("mid_rst_data", 16'(data_out), 16'h0000);
        sel = 2'($urandom_range(0, 3));
        br_sel = sel;
        tick();
        chk("in_rst_ctrl", 16'(ctrl_s), 16'(5'b00010));
        @(negedge clk);
        rst = 1'b0;
        quiet("restart", 2, 1'b1);
        exp_auto("restart", sel);
        applied = sel;
        quiet("final", 5, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
